// File: rtl/gpio_result_transmitter.sv
// Queues filtered result bytes and hands them to a Raspberry Pi over an 8-bit bus
// with a strobe/ack handshake, dropping any byte the Pi fails to acknowledge in time.
module gpio_result_transmitter #(
   parameter int FIFO_DEPTH   = 4,
   parameter int SETUP_CYCLES = 2,
   parameter int ACK_TIMEOUT  = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] rpi_gpio_tri_io_o,
   output logic       rpi_strobe_o,
   input  logic       rpi_ack_i,
   output logic [4:0] fifo_level,
   output logic       timeout_pulse,
   output logic [7:0] drop_count
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      STROBE_HI,
      STROBE_LO
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [4:0]       level_q, level_d;
   logic             ack_meta_q, ack_meta_d;
   logic             ack_s_q, ack_s_d;
   logic [3:0]       setup_cnt_q, setup_cnt_d;
   logic [15:0]      tmo_cnt_q, tmo_cnt_d;
   logic [7:0]       bus_q, bus_d;
   logic             strobe_q, strobe_d;
   logic             tmo_pulse_q, tmo_pulse_d;
   logic [7:0]       drop_q, drop_d;
   logic             push;
   logic             pop;

   assign in_ready = !rst && (level_q < 5'(FIFO_DEPTH));
   assign push     = in_valid && in_ready;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
      state_d     = state_q;
      bus_d       = bus_q;
      setup_cnt_d = setup_cnt_q;
      tmo_cnt_d   = tmo_cnt_q;
      tmo_pulse_d = 1'b0;
      drop_d      = drop_q;
      pop         = 1'b0;
      ack_meta_d  = rpi_ack_i;
      ack_s_d     = ack_meta_q;

      case (state_q)
         IDLE: begin
            if ((level_q != 5'd0) && !ack_s_q) begin
               bus_d       = mem_q[rd_ptr_q];
               setup_cnt_d = 4'(SETUP_CYCLES);
               state_d     = SETUP;
            end
         end
         SETUP: begin
            if (setup_cnt_q == 4'd0) begin
               tmo_cnt_d = '0;
               state_d   = STROBE_HI;
            end else begin
               setup_cnt_d = setup_cnt_q - 4'd1;
            end
         end
         STROBE_HI: begin
            // An ack arriving on the last allowed cycle still completes the transfer.
            if (ack_s_q) begin
               state_d = STROBE_LO;
            end else if (tmo_cnt_q == 16'(ACK_TIMEOUT - 1)) begin
               pop         = 1'b1;
               tmo_pulse_d = 1'b1;
               if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
               state_d     = IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 16'd1;
            end
         end
         STROBE_LO: begin
            if (!ack_s_q) begin
               pop     = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      strobe_d = (state_d == STROBE_HI);
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      level_d  = level_q + 5'(push) - 5'(pop);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         ack_meta_q  <= 1'b0;
         ack_s_q     <= 1'b0;
         setup_cnt_q <= '0;
         tmo_cnt_q   <= '0;
         bus_q       <= 8'h00;
         strobe_q    <= 1'b0;
         tmo_pulse_q <= 1'b0;
         drop_q      <= 8'h00;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         ack_meta_q  <= ack_meta_d;
         ack_s_q     <= ack_s_d;
         setup_cnt_q <= setup_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
         bus_q       <= bus_d;
         strobe_q    <= strobe_d;
         tmo_pulse_q <= tmo_pulse_d;
         drop_q      <= drop_d;
      end
   end

   // NOTE: FIFO storage is not reset; pointers and level qualify every read.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_data;
   end

   assign rpi_gpio_tri_io_o = bus_q;
   assign rpi_strobe_o      = strobe_q;
   assign fifo_level        = level_q;
   assign timeout_pulse     = tmo_pulse_q;
   assign drop_count        = drop_q;

endmodule

// File: tb/tb_gpio_result_transmitter.sv
// Directed bench for gpio_result_transmitter: cycle table for a single transfer and a
// FIFO fill, then hand-written timeout, stuck-ack, reset and push/pop sequences.
module tb_gpio_result_transmitter;

   localparam int DEPTH = 4;
   localparam int SETUP = 2;
   localparam int TMO   = 1000;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] rpi_gpio_tri_io_o;
   logic       rpi_strobe_o;
   logic       rpi_ack_i;
   logic [4:0] fifo_level;
   logic       timeout_pulse;
   logic [7:0] drop_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   gpio_result_transmitter #(
      .FIFO_DEPTH  (DEPTH),
      .SETUP_CYCLES(SETUP),
      .ACK_TIMEOUT (TMO)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .in_data          (in_data),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .rpi_gpio_tri_io_o(rpi_gpio_tri_io_o),
      .rpi_strobe_o     (rpi_strobe_o),
      .rpi_ack_i        (rpi_ack_i),
      .fifo_level       (fifo_level),
      .timeout_pulse    (timeout_pulse),
      .drop_count       (drop_count)
   );

   typedef struct {
      logic       valid;
      logic [7:0] data;
      logic       ack;
      logic       exp_ready;
      logic [4:0] exp_level;
      logic       exp_strobe;
      logic [7:0] exp_bus;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic v, input logic [7:0] d, input logic a,
                               input logic r, input logic [4:0] l, input logic s,
                               input logic [7:0] b);
      vec_t x;
      x.valid = v; x.data = d; x.ack = a;
      x.exp_ready = r; x.exp_level = l; x.exp_strobe = s; x.exp_bus = b;
      return x;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   // Pi side of one transfer: wait for strobe, capture the byte, ack until strobe drops.
   task automatic handshake(input string name, input logic [7:0] exp);
      int n;
      logic [7:0] got;
      logic stable;
      n = 0;
      while (rpi_strobe_o !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      check({name, "_strobe"}, 32'(rpi_strobe_o), 32'd1);
      got = rpi_gpio_tri_io_o;
      check({name, "_bus"}, 32'(got), 32'(exp));
      rpi_ack_i = 1'b1;
      stable = 1'b1;
      n = 0;
      while (rpi_strobe_o === 1'b1 && n < 100) begin
         tick();
         n++;
         if (rpi_gpio_tri_io_o !== got) stable = 1'b0;
      end
      check({name, "_release"}, 32'(rpi_strobe_o), 32'd0);
      check({name, "_stable"}, 32'(stable), 32'd1);
      rpi_ack_i = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      logic seen;

      // Single byte A5: ack raised 3 clocks after strobe, released 3 clocks later.
      vecs.push_back(mk(1, 8'hA5, 0, 1, 1, 0, 8'h00));
      vecs.push_back(mk(0, 8'h00, 0, 1, 1, 0, 8'hA5));
      vecs.push_back(mk(0, 8'h00, 0, 1, 1, 0, 8'hA5));
      vecs.push_back(mk(0, 8'h00, 0, 1, 1, 0, 8'hA5));
      vecs.push_back(mk(0, 8'h00, 0, 1, 1, 1, 8'hA5));
      vecs.push_back(mk(0, 8'h00, 0, 1, 1, 1, 8'hA5));
      vecs.push_back(mk(0, 8'h00, 0, 1, 1, 1, 8'hA5));
      vecs.push_back(mk(0, 8'h00, 1, 1, 1, 1, 8'hA5));
      vecs.push_back(mk(0, 8'h00, 1, 1, 1, 1, 8'hA5));
      vecs.push_back(mk(0, 8'h00, 1, 1, 1, 0, 8'hA5));
      vecs.push_back(mk(0, 8'h00, 0, 1, 1, 0, 8'hA5));
      vecs.push_back(mk(0, 8'h00, 0, 1, 1, 0, 8'hA5));
      vecs.push_back(mk(0, 8'h00, 0, 1, 0, 0, 8'hA5));
      vecs.push_back(mk(0, 8'h00, 0, 1, 0, 0, 8'hA5));
      // Fill: 01..05 back-to-back, 05 arrives when full and is refused.
      vecs.push_back(mk(1, 8'h01, 0, 1, 1, 0, 8'hA5));
      vecs.push_back(mk(1, 8'h02, 0, 1, 2, 0, 8'h01));
      vecs.push_back(mk(1, 8'h03, 0, 1, 3, 0, 8'h01));
      vecs.push_back(mk(1, 8'h04, 0, 0, 4, 0, 8'h01));
      vecs.push_back(mk(1, 8'h05, 0, 0, 4, 1, 8'h01));
      vecs.push_back(mk(0, 8'h00, 0, 0, 4, 1, 8'h01));

      rst = 1'b1;
      in_valid = 1'b0;
      in_data = 8'h00;
      rpi_ack_i = 1'b0;
      tick();
      tick();
      check("rst_ready", 32'(in_ready), 32'd0);
      check("rst_level", 32'(fifo_level), 32'd0);
      check("rst_strobe", 32'(rpi_strobe_o), 32'd0);
      check("rst_bus", 32'(rpi_gpio_tri_io_o), 32'h00);
      check("rst_pulse", 32'(timeout_pulse), 32'd0);
      check("rst_drops", 32'(drop_count), 32'd0);
      rst = 1'b0;
      #1;
      check("post_rst_ready", 32'(in_ready), 32'd1);

      foreach (vecs[i]) begin
         in_valid  = vecs[i].valid;
         in_data   = vecs[i].data;
         rpi_ack_i = vecs[i].ack;
         tick();
         check($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(vecs[i].exp_ready));
         check($sformatf("vec%0d_level", i), 32'(fifo_level), 32'(vecs[i].exp_level));
         check($sformatf("vec%0d_strobe", i), 32'(rpi_strobe_o), 32'(vecs[i].exp_strobe));
         check($sformatf("vec%0d_bus", i), 32'(rpi_gpio_tri_io_o), 32'(vecs[i].exp_bus));
      end
      in_valid = 1'b0;

      handshake("fill01", 8'h01);
      handshake("fill02", 8'h02);
      handshake("fill03", 8'h03);
      handshake("fill04", 8'h04);
      repeat (6) tick();
      check("fill_level_end", 32'(fifo_level), 32'd0);
      check("fill_no_05", 32'(rpi_strobe_o), 32'd0);

      // Timeout: no ack ever arrives for 3C.
      push_byte(8'h3C);
      n = 0;
      while (rpi_strobe_o !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check("tmo_strobe_latency", 32'(n), 32'(SETUP + 2));
      n = 0;
      while (rpi_strobe_o === 1'b1 && n < TMO + 20) begin
         tick();
         n++;
      end
      check("tmo_high_cycles", 32'(n), 32'(TMO));
      check("tmo_pulse_hi", 32'(timeout_pulse), 32'd1);
      check("tmo_drops", 32'(drop_count), 32'd1);
      check("tmo_level", 32'(fifo_level), 32'd0);
      tick();
      check("tmo_pulse_lo", 32'(timeout_pulse), 32'd0);
      seen = 1'b0;
      repeat (10) begin
         tick();
         if (rpi_strobe_o !== 1'b0) seen = 1'b1;
      end
      check("tmo_no_resend", 32'(seen), 32'd0);

      // Stuck ack: ack held high while bytes wait in the FIFO.
      rpi_ack_i = 1'b1;
      repeat (3) tick();
      push_byte(8'h77);
      push_byte(8'h88);
      seen = 1'b0;
      repeat (10) begin
         tick();
         if (rpi_strobe_o !== 1'b0) seen = 1'b1;
      end
      check("stuck_no_strobe", 32'(seen), 32'd0);
      check("stuck_level", 32'(fifo_level), 32'd2);
      check("stuck_bus_held", 32'(rpi_gpio_tri_io_o), 32'h3C);
      rpi_ack_i = 1'b0;
      handshake("stuck77", 8'h77);
      handshake("stuck88", 8'h88);
      repeat (6) tick();
      check("stuck_level_end", 32'(fifo_level), 32'd0);

      // Reset while strobe is high with three bytes queued.
      push_byte(8'h11);
      push_byte(8'h22);
      push_byte(8'h33);
      n = 0;
      while (rpi_strobe_o !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check("rstx_strobe_seen", 32'(rpi_strobe_o), 32'd1);
      check("rstx_level_pre", 32'(fifo_level), 32'd3);
      rst = 1'b1;
      #1;
      check("rstx_ready_in_rst", 32'(in_ready), 32'd0);
      tick();
      check("rstx_strobe", 32'(rpi_strobe_o), 32'd0);
      check("rstx_bus", 32'(rpi_gpio_tri_io_o), 32'h00);
      check("rstx_level", 32'(fifo_level), 32'd0);
      check("rstx_drops", 32'(drop_count), 32'd0);
      check("rstx_pulse", 32'(timeout_pulse), 32'd0);
      rst = 1'b0;
      seen = 1'b0;
      repeat (8) begin
         tick();
         if (rpi_strobe_o !== 1'b0) seen = 1'b1;
      end
      check("rstx_no_resend", 32'(seen), 32'd0);

      // Push and pop on the same edge at level 2.
      push_byte(8'hAA);
      push_byte(8'hBB);
      n = 0;
      while (rpi_strobe_o !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check("pp_bus_aa", 32'(rpi_gpio_tri_io_o), 32'hAA);
      rpi_ack_i = 1'b1;
      n = 0;
      while (rpi_strobe_o === 1'b1 && n < 20) begin
         tick();
         n++;
      end
      rpi_ack_i = 1'b0;
      tick();
      tick();
      check("pp_level_before", 32'(fifo_level), 32'd2);
      push_byte(8'hCC);
      check("pp_level_after", 32'(fifo_level), 32'd2);
      handshake("ppBB", 8'hBB);
      handshake("ppCC", 8'hCC);
      repeat (6) tick();
      check("pp_level_end", 32'(fifo_level), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
